// File: rtl/scm_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : scm_lut_loader
// Purpose  : Write-side sequencer for the latch-based LUT memory (scm).
//            Accepts a load command (base address + word count) and a
//            valid/ready stream of LUT words. Drives the scm write port with
//            registered address/data/enable, one word per cycle. busy_o marks
//            the window in which the scm region must not be read.
// Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//            cmd_valid_i/cmd_ready_o - command handshake
//            cmd_base_i, cmd_len_i   - first scm address, number of words
//            abort_i                 - terminate the load in progress
//            data_valid_i/data_ready_o, data_i - LUT word stream
//            scm_waddr_o, scm_wdata_o, scm_we_o - scm write port
//            busy_o, done_o, err_o   - load status
// Revision : 1.0 - initial release
// ============================================================================
module scm_lut_loader #(
  parameter int unsigned C              = 32,
  parameter int unsigned K              = 16,
  parameter int unsigned DataTypeWidth  = 16,
  parameter int unsigned TotalAddrWidth = $clog2(C*K),
  parameter int unsigned LenWidth       = TotalAddrWidth + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [TotalAddrWidth-1:0] cmd_base_i,
  input  logic [LenWidth-1:0]       cmd_len_i,
  input  logic                      abort_i,
  input  logic                      data_valid_i,
  output logic                      data_ready_o,
  input  logic [DataTypeWidth-1:0]  data_i,
  output logic [TotalAddrWidth-1:0] scm_waddr_o,
  output logic [DataTypeWidth-1:0]  scm_wdata_o,
  output logic                      scm_we_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN1 = 2'd2,
    DRAIN2 = 2'd3
  } state_e;

  // Range check is done one bit wider than the length field so that
  // base + len can never wrap back into the legal range.
  localparam int unsigned        c_PAD   = LenWidth + 1 - TotalAddrWidth;
  localparam logic [LenWidth:0]  c_DEPTH = (LenWidth+1)'(C*K);

  state_e                    r_state;
  state_e                    w_state_next;
  logic [TotalAddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]       r_remaining;
  logic [TotalAddrWidth-1:0] r_waddr;
  logic [DataTypeWidth-1:0]  r_wdata;
  logic                      r_we;
  logic                      r_done;
  logic                      r_err;

  logic                      w_cmd_hs;
  logic                      w_reject;
  logic [LenWidth:0]         w_end;
  logic                      w_last;

  assign w_cmd_hs = cmd_valid_i && (r_state == IDLE);
  assign w_end    = {{c_PAD{1'b0}}, cmd_base_i} + {1'b0, cmd_len_i};
  assign w_reject = (cmd_len_i == '0) || (w_end > c_DEPTH);
  assign w_last   = (r_remaining == LenWidth'(1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and decoded status outputs
  always_comb begin
    w_state_next = r_state;
    cmd_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (w_cmd_hs && !w_reject) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        data_ready_o = 1'b1;
        // Abort wins over a same-cycle handshake; drain still runs so the
        // writes already issued reach the latches.
        if (abort_i) begin
          w_state_next = DRAIN1;
        end else if (data_valid_i && w_last) begin
          w_state_next = DRAIN1;
        end
      end
      DRAIN1:  w_state_next = DRAIN2;
      DRAIN2:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Address/length counters, registered write port and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd_hs) begin
            r_err <= w_reject;
            if (w_reject) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= cmd_base_i;
              r_remaining <= cmd_len_i;
            end
          end
        end
        LOAD: begin
          if (abort_i) begin
            r_err <= 1'b1;
          end else if (data_valid_i) begin
            r_waddr     <= r_addr;
            r_wdata     <= data_i;
            r_we        <= 1'b1;
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        DRAIN2: begin
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign scm_waddr_o = r_waddr;
  assign scm_wdata_o = r_wdata;
  assign scm_we_o    = r_we;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_scm_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_scm_lut_loader
// Purpose  : Self-checking bench for scm_lut_loader. Expected scm writes are
//            queued as words are handed to the DUT and matched against the
//            scm write port; a shadow memory is compared at the end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scm_lut_loader;

  localparam int C     = 32;
  localparam int K     = 16;
  localparam int DW    = 16;
  localparam int DEPTH = C * K;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic          abort;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          busy;
  logic          done;
  logic          err;

  scm_lut_loader #(
    .C(C), .K(K), .DataTypeWidth(DW), .TotalAddrWidth(AW), .LenWidth(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .abort_i(abort),
    .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data),
    .scm_waddr_o(waddr), .scm_wdata_o(wdata), .scm_we_o(we),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   sb[$];
  logic [31:0]   sb_head;
  logic [DW-1:0] exp_mem[DEPTH];
  logic [DW-1:0] cap_mem[DEPTH];

  typedef struct {
    int base;
    int len;
    int gap;        // 0: continuous data, 1: valid pattern 1,0,0,...
    int abort_idx;  // handshake index that carries abort, -1 for none
    int salt;       // XORed into data; 0 gives data == address
    bit reject;
    bit exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every scm write must match the oldest queued expectation.
  always @(posedge clk) begin
    #2;
    if (we === 1'b1) begin
      chk("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        sb_head = sb.pop_front();
        chk("write_addr_data", 32'({waddr, wdata}), sb_head);
      end
      cap_mem[waddr] = wdata;
    end
  end

  // Starts at a negedge with the DUT idle; returns at the negedge where
  // done_o is expected high, so a caller may issue the next command at once.
  task automatic run_load(input int base, input int len, input int gap,
                          input int abort_idx, input int salt,
                          input bit reject, input bit exp_err);
    int hs;
    int cyc;
    bit aborted;
    logic v;
    logic [DW-1:0] d;
    cmd_valid = 1'b1;
    cmd_base  = AW'(base);
    cmd_len   = LW'(len);
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (reject) begin
      chk("rej_done", 32'(done), 32'd1);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      chk("rej_we", 32'(we), 32'd0);
      return;
    end
    chk("load_data_ready", 32'(data_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_err_clear", 32'(err), 32'd0);
    hs = 0;
    cyc = 0;
    aborted = 1'b0;
    while (hs < len && !aborted && cyc < 4000) begin
      v = (gap == 0) ? 1'b1 : ((cyc % 3) == 0);
      d = DW'(base + hs) ^ DW'(salt);
      data_valid = v;
      data       = d;
      abort      = v && (hs == abort_idx);
      if (v && hs == abort_idx) begin
        aborted = 1'b1;
      end else if (v) begin
        sb.push_back(32'({AW'(base + hs), d}));
        exp_mem[base + hs] = d;
        hs++;
      end
      cyc++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    abort      = 1'b0;
    chk("load_within_budget", 32'(cyc < 4000), 32'd1);
    chk("drain1_busy", 32'(busy), 32'd1);
    chk("drain1_data_ready", 32'(data_ready), 32'd0);
    chk("drain1_err", 32'(err), 32'(exp_err));
    chk("drain1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("drain2_we", 32'(we), 32'd0);
    chk("drain2_busy", 32'(busy), 32'd1);
    chk("drain2_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err", 32'(err), 32'(exp_err));
    chk("done_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          base len gap abort salt rej err
    vecs[0] = '{0,   512, 0, -1,   0,      0, 0};  // full load, data == addr
    vecs[1] = '{100, 5,   1, -1,   16'h5A3C, 0, 0};  // gapped partial load
    vecs[2] = '{510, 3,   0, -1,   0,      1, 1};  // overruns the end
    vecs[3] = '{510, 0,   0, -1,   0,      1, 1};  // zero length
    vecs[4] = '{510, 2,   0, -1,   16'h1234, 0, 0};  // exactly reaches the end
    vecs[5] = '{0,   16,  0, 3,    16'hBEEF, 0, 1};  // abort on 4th handshake
    vecs[6] = '{200, 4,   0, -1,   16'h0F0F, 0, 0};  // clears err

    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
      cap_mem[i] = '0;
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_base = '0;
    cmd_len = '0;
    abort = 1'b0;
    data_valid = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i].base, vecs[i].len, vecs[i].gap, vecs[i].abort_idx,
               vecs[i].salt, vecs[i].reject, vecs[i].exp_err);
      @(negedge clk);
      chk("done_single_cycle", 32'(done), 32'd0);
    end

    // Back-to-back: second command offered in the done cycle of the first.
    run_load(300, 3, 0, -1, 16'h7777, 1'b0, 1'b0);
    run_load(310, 2, 1, -1, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);

    // Reset after 7 of 20 words.
    cmd_valid = 1'b1;
    cmd_base  = AW'(400);
    cmd_len   = LW'(20);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_valid = 1'b1;
      data = DW'(400 + i) ^ 16'hC0DE;
      sb.push_back(32'({AW'(400 + i), data}));
      exp_mem[400 + i] = data;
      @(negedge clk);
    end
    data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_data_ready", 32'(data_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_waddr", 32'(waddr), 32'd0);
    @(negedge clk);
    chk("mid_rst_no_done", 32'(done), 32'd0);
    run_load(450, 1, 0, -1, 16'h4242, 1'b0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("readback[%0d]", i), 32'(cap_mem[i]), 32'(exp_mem[i]));
    end
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
